// File: rtl/paper_drain_pkg.sv
// Shared types and helpers for the systolic column drain (state enum, index width, signed clamp).
// Latency: none, it holds types and pure functions only.
// Backpressure: none.
package paper_drain_pkg;

    // Drain controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    // Row-index width. A single-row column still gets a 1-bit index so the port never collapses.
    function automatic int idx_width(input int rows);
        int w;
        w = $clog2(rows);
        return (w < 1) ? 1 : w;
    endfunction

    // Signed clamp of a sign-extended accumulator to the range of an out_w-bit signed value.
    function automatic longint sat_clamp(input longint v, input int out_w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (out_w - 1)) - longint'(1);
        lo = -(longint'(1) <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/paper_drain_fifo.sv
// Synchronous FIFO of {data, row index}; the head is read straight out of the storage registers.
// Latency: one cycle from push to head_vld_o, no bypass into an empty FIFO.
// Backpressure: full_o is exported; a push while full is taken only if the head pops in the same cycle.
module paper_drain_fifo #(
    parameter int DW    = 32,
    parameter int IW    = 3,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic [IW-1:0] push_idx_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          head_vld_o,
    output logic [DW-1:0] head_dat_o,
    output logic [IW-1:0] head_idx_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] dat_q [DEPTH];
    logic [IW-1:0] idx_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly at DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_vld_o = (cnt_q != '0);
    assign full_o     = (cnt_q == CW'(DEPTH));
    assign do_pop     = pop_i && head_vld_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign head_dat_o = dat_q[rd_ptr_q];
    assign head_idx_o = idx_q[rd_ptr_q];

    // Next pointers and occupancy; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else if (do_push) begin
            dat_q[wr_ptr_q] <= push_dat_i;
            idx_q[wr_ptr_q] <= push_idx_i;
        end
    end

endmodule

// File: rtl/paper_systolic_drain.sv
// Drains one systolic PE column bottom-up into a FIFO and streams {data,row} out (PAPER_DRAIN_SAT_EN adds clamping + satSeen).
// Latency: ROWS+2 cycles from drainStart to drainDone with outReady held high; each word visible one cycle after its shift.
// Backpressure: the column shift enable is withheld while the FIFO is full and its head is not popping.
module paper_systolic_drain
    import paper_drain_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int ACC       = 32,
    parameter int DEPTH     = 4,
    parameter int OUT_WIDTH = 16,
    localparam int IW       = idx_width(ROWS)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           drainStart,
    input  logic [ACC-1:0] cIn,
    output logic           enableShiftOut,
    output logic           drainBusy,
    output logic           drainDone,
    output logic           outValid,
    input  logic           outReady,
    output logic [ACC-1:0] outData,
    output logic [IW-1:0]  outIndex,
    output logic           outLast
`ifdef PAPER_DRAIN_SAT_EN
    ,
    output logic           satSeen
`endif
);

    if (ROWS < 1 || DEPTH < 1 || OUT_WIDTH < 1) begin : g_bad_cfg
        $error("paper_systolic_drain: ROWS, DEPTH and OUT_WIDTH must be >= 1");
    end

    drain_state_e   state_q;
    logic [IW-1:0]  row_q;
    logic           done_q;
    logic           fifo_full;
    logic           head_pop;
    logic [ACC-1:0] push_dat;

    assign head_pop  = outValid && outReady;
    assign drainBusy = (state_q != IDLE);
    assign drainDone = done_q;
    assign outLast   = outValid && (outIndex == '0);

    // Shift only when the pushed word has a slot; reset kills the shift in the cycle it is sampled.
    assign enableShiftOut = !reset && (state_q == SHIFT) && (!fifo_full || head_pop);

`ifdef PAPER_DRAIN_SAT_EN
    if (ACC > 64 || OUT_WIDTH > ACC) begin : g_bad_sat_cfg
        $error("paper_systolic_drain: saturation needs OUT_WIDTH <= ACC <= 64");
    end

    longint sat_in;
    longint sat_out;
    logic   clamped;
    logic   sat_q;

    // Clamp the bottom PE value as signed ACC and sign-extend back to ACC bits.
    always_comb begin
        sat_in   = longint'($signed(cIn));
        sat_out  = sat_clamp(sat_in, OUT_WIDTH);
        push_dat = ACC'(sat_out);
        clamped  = (sat_out != sat_in);
    end

    // Sticky per-pass flag: cleared when a pass is accepted, set by any clamped push.
    always_ff @(posedge clock) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if ((state_q == IDLE) && drainStart) begin
            sat_q <= 1'b0;
        end else if (enableShiftOut && clamped) begin
            sat_q <= 1'b1;
        end
    end

    assign satSeen = sat_q;
`else
    assign push_dat = cIn;
`endif

    // Drain FSM: accept a pass, count rows down as they shift, then wait for the row-0 word to leave.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= IW'(ROWS - 1);
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (drainStart) begin
                        state_q <= SHIFT;
                        row_q   <= IW'(ROWS - 1);
                    end
                end
                SHIFT: begin
                    if (enableShiftOut) begin
                        if (row_q == '0) begin
                            state_q <= FLUSH;
                        end else begin
                            row_q <= row_q - IW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (head_pop && outLast) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    paper_drain_fifo #(
        .DW    (ACC),
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clock),
        .rst_i      (reset),
        .push_i     (enableShiftOut),
        .push_dat_i (push_dat),
        .push_idx_i (row_q),
        .pop_i      (head_pop),
        .full_o     (fifo_full),
        .head_vld_o (outValid),
        .head_dat_o (outData),
        .head_idx_o (outIndex)
    );

endmodule

// File: doc/paper_systolic_drain.md
Name: paper_systolic_drain

Overview:
- Sits at the bottom of one column of integer systolic PEs and collects the column's accumulators.
- Once the multiply phase ends, it drives the column's shift-out enable and captures the bottom PE's accumulator each shift cycle.
- Captured values are buffered in a small FIFO and presented on a valid/ready stream to the writeback path.
- It applies backpressure by withholding the shift enable, so no accumulator value is ever lost.

Parameters:
- ROWS, 8, number of PEs in the column (values drained per pass); must be ≥1.
- ACC, 32, accumulator width in bits.
- DEPTH, 4, FIFO depth in entries; must be ≥1 (power of two not required).
- OUT_WIDTH, 16, saturation width; used only when PAPER_DRAIN_SAT_EN is defined.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- drainStart  in  1  one-cycle request to begin a drain pass.
- cIn  in  ACC  cOut of the bottom PE in the column.
- enableShiftOut  out  1  shift enable broadcast to every PE in the column.
- drainBusy  out  1  high from accept until the last word has left the FIFO; the controller must hold enableMul low while it is high.
- drainDone  out  1  one-cycle pulse on the cycle after the last word handshakes.
- outValid  out  1  FIFO head is valid.
- outReady  in  1  consumer accepts the head.
- outData  out  ACC  accumulator value at the FIFO head.
- outIndex  out  $clog2(ROWS) (min 1)  source row of outData; 0 is the top row.
- outLast  out  1  outData is the final word of the pass (row 0).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; FIFO empty; row counter=ROWS-1. All outputs are 0: enableShiftOut, drainBusy, drainDone, outValid, outData, outIndex, outLast.
- Reset mid-pass: FIFO contents are discarded. enableShiftOut drops the same cycle reset is sampled. The PE column is reset by the same signal.
- States: IDLE, SHIFT, FLUSH.
- IDLE:
  - drainStart=1 → SHIFT next cycle, with rowCnt=ROWS-1.
  - drainBusy=0 in IDLE.
- SHIFT:
  - Combinational: enableShiftOut = !fifoFull || (outValid && outReady).
  - Each cycle enableShiftOut=1: push {cIn, rowCnt} on the same edge the column shifts.
  - First word pushed is the bottom row (ROWS-1); the last is row 0.
  - When row 0 is pushed → FLUSH. Otherwise rowCnt decrements.
  - Exactly ROWS shift cycles occur per pass, never more.
- FLUSH:
  - enableShiftOut=0.
  - When the last word handshakes (outValid && outReady && outLast) → IDLE, and drainDone=1 on the following cycle.
- drainStart while drainBusy=1 is ignored. It is not queued.
- drainBusy=1 in SHIFT and FLUSH.
- Latency: the first word is visible at outValid one cycle after its shift edge (registered FIFO output).
  - With outReady held high and DEPTH ≥1, the pass completes in ROWS+2 cycles from drainStart to drainDone.
- FIFO boundaries:
  - A push and a pop in the same cycle when full are allowed; occupancy is unchanged.
  - A push into an empty FIFO is not bypassed; it takes one cycle.
  - The pop pointer wraps at DEPTH.
- outData, outIndex and outLast hold stable while outValid && !outReady.
- outLast = (outIndex == 0) && outValid.
- Width rules: outData is the raw ACC bits with no truncation. outIndex is the row number.

Optional Feature:
- Macro: PAPER_DRAIN_SAT_EN.
- Defined: each pushed value is treated as signed ACC. It is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and sign-extended back to ACC bits before entering the FIFO.
  - A sticky output `satSeen` (1 bit, reset 0, cleared on drainStart accept) goes high if any value in the pass was clamped.
- Undefined: values pass unmodified. The satSeen port is absent and OUT_WIDTH is unused.

Decomposition:
- Shared package paper_drain_pkg holds:
  - the state enum (IDLE, SHIFT, FLUSH);
  - a function computing the row-index width, max(1, $clog2(ROWS));
  - the saturation function (signed clamp of ACC to OUT_WIDTH).
- One sub-module: paper_drain_fifo. It is a parameterised synchronous FIFO of {data, index} with full/empty, simultaneous push/pop when full, and a registered head.

Test Plan:
- ROWS=4, DEPTH=4, outReady=1; column cOut presents 40,30,20,10 on successive shifts:
  - enableShiftOut is high exactly 4 cycles;
  - outputs are (40,idx3),(30,idx2),(20,idx1),(10,idx0,outLast);
  - drainDone pulses at cycle 6 after drainStart.
- ROWS=4, DEPTH=2, outReady=0 for 10 cycles then 1:
  - enableShiftOut drops after 2 shifts;
  - no word is lost or duplicated;
  - all 4 values arrive in order.
- outReady toggled 1,0,1,0 during the pass:
  - outData and outIndex hold while stalled;
  - total shifts = 4;
  - drainDone appears exactly once.
- drainStart pulsed again in SHIFT and in FLUSH:
  - ignored, with no extra shifts;
  - a later drainStart in IDLE starts a fresh pass with rowCnt=3.
- reset asserted on the 2nd shift cycle:
  - next cycle enableShiftOut, outValid and drainBusy are all 0 and the FIFO is empty;
  - a subsequent pass completes normally.
- With PAPER_DRAIN_SAT_EN, OUT_WIDTH=8:
  - pushed -300 → -128 and 200 → 127, with satSeen=1;
  - a pass with values within ±100 gives satSeen=0.
